// File: rtl/inv_debounce_bank.sv
// Bank of WIDTH input conditioners. Each channel runs through a two-flop
// synchroniser, a debounce filter and a programmable inversion mask. The
// output is registered, and each channel produces one-cycle rise/fall pulses.
module inv_debounce_bank #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             mask_load,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] st;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] cond;

  // Two-flop synchroniser for the asynchronous input lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: accept a new level after DB_CYCLES consecutive disagreements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Inversion mask register, loaded for all channels at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (mask_load) begin
      mask <= mask_in;
    end
  end

  // Conditioned level before the output register
  always_comb begin
    cond = st ^ mask;
  end

  // Registered output with edge pulses derived from the previous output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '1;
      rise <= '0;
      fall <= '0;
    end else begin
      dout <= cond;
      rise <= cond & ~dout;
      fall <= ~cond & dout;
    end
  end

endmodule

// File: doc/inv_debounce_bank.md
# inv_debounce_bank

Parametrised successor to the single-bit inverter. It conditions WIDTH asynchronous input lines, such as board switches and push-buttons, through three stages: a two-flop synchroniser, a per-channel debounce filter and a per-channel programmable inversion mask. Each output is registered, and one-cycle rise/fall pulses are generated per channel. The block sits between the board I/O pins and the lab logic. With the reset mask it behaves as a bank of clean, debounced NOT gates.

## Interface
- WIDTH, 8: number of channels (≥1).
- DB_CYCLES, 4: consecutive synchronised cycles a new level must persist before it is accepted (≥1).
- CNT_W, $clog2(DB_CYCLES+1): debounce counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  raw asynchronous input lines.
- mask_in  input  WIDTH  new inversion mask; 1 = invert that channel.
- mask_load  input  1  when high at a clock edge, mask ← mask_in.
- mask  output  WIDTH  current inversion mask.
- dout  output  WIDTH  registered, conditioned output, equal to stable level XOR mask.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0→1.
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1→0.

## Operation
- Reset (rst_n low, asynchronous): all internal state and outputs take these values.
  - sync1, sync2, stable level st: all 0.
  - Debounce counters: 0.
  - mask: all 1s.
  - dout: all 1s, since st=0 XOR mask=1.
  - rise, fall: all 0.
- Synchroniser, per channel: sync1 ← din, then sync2 ← sync1.
- Debounce, per channel, with an independent counter cnt:
  - sync2 == st: cnt ← 0.
  - sync2 != st and cnt < DB_CYCLES−1: cnt ← cnt+1.
  - sync2 != st and cnt == DB_CYCLES−1: st ← sync2, cnt ← 0.
  - A disagreement lasting fewer than DB_CYCLES consecutive cycles at sync2 never reaches st.
- Mask: on any edge with mask_load=1, mask ← mask_in. The load is applied to all channels at once. mask_load=0 holds the mask.
- Output register, every edge:
  - dout ← st XOR mask, using the register values before the edge.
  - rise ← (st XOR mask) & ~dout.
  - fall ← ~(st XOR mask) & dout.
- A mask reload that flips a channel's output produces rise/fall pulses exactly like a debounced input change.
- Simultaneous st change and mask flip on the same channel:
  - If both take effect at the same edge, the XOR may be unchanged. In that case dout does not change and no pulse is generated.
- Channels are fully independent. A change on one channel never affects the counter or outputs of another.
- Counters never exceed DB_CYCLES−1. No wrap-around is possible.

## Timing
- Input path latency: din changes before edge E1 and is held. Then:
  - sync2 updates at E2.
  - st updates at E(2+DB_CYCLES).
  - dout, rise and fall update at E(3+DB_CYCLES).
  - With DB_CYCLES=4 this is the 7th edge.
  - With DB_CYCLES=1 it is the 4th edge.
- Mask path latency: mask_load at edge E gives mask visible after E, and dout/rise/fall at E+1.
- Pulse width: rise and fall are high for exactly one cycle per dout transition. They are never high together on the same channel.
- Reset mid-operation:
  - Outputs return to their reset values immediately, without waiting for a clock.
  - Partial debounce counts are discarded.
  - After rst_n deasserts, a held din=1 needs the full 3+DB_CYCLES edges to appear.
- Deassertion of rst_n is assumed synchronous to clk, supplied by the board reset conditioner.

## Test plan
1. Reset check (WIDTH=8, DB_CYCLES=4): assert rst_n=0 with din=8'hA5 → dout=8'hFF, mask=8'hFF, rise=fall=0, with no clock edge required.
2. Debounce pass: after reset, hold din=8'h01 → dout=8'hFE exactly at the 7th edge. fall=8'h01 for that one cycle only; rise stays 0.
3. Glitch reject: pulse din[1]=1 for 3 cycles, then 0 → dout, rise and fall never change. Then hold din[1] for 4 cycles → dout[1]=0 on schedule.
4. Mask load: with din=0 stable, load mask_in=8'h0F (mask_load high for 1 cycle).
   - mask=8'h0F after that edge.
   - At the next edge, dout=8'h0F and fall=8'hF0 for one cycle.
5. Reset mid-count: hold din=8'hFF and assert rst_n=0 at edge 4 → dout=8'hFF immediately. Release rst_n → dout becomes 8'h00 only 7 edges after release, with fall=8'hFF pulsed once.
6. Simultaneous events: time mask_load with mask_in[2]=0 to land on the same edge as st[2] rising → dout[2] stays 1 and no pulse occurs on channel 2. Other channels are unaffected.
